// File: rtl/pool_pkg.sv
// Shared constants and FSM encoding for the pooling scheduler.
// Optional feature: POOL_SCHED_RR_EN (round-robin single-lane grant).
package pool_pkg;

  localparam int NLANE = 4;  // conv lanes feeding the pooler
  localparam int CW    = 3;  // column index width per lane
  localparam int LW    = 2;  // lane index width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    POOL = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/pool_rr_arb.sv
// Round-robin lane grant: one lane per cycle, search starts at the pointer,
// pointer moves just past the granted lane.
module pool_rr_arb
  import pool_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NLANE-1:0] req,
  output logic [NLANE-1:0] grant
);

  logic [LW-1:0] ptr;
  logic [LW-1:0] gidx;
  logic [LW-1:0] idx;
  logic          found;

  // Pick the first requesting lane at or after the pointer
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      idx = ptr + LW'(i);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  // Advance the pointer past the lane that was granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= gidx + 1'b1;
    end
  end

endmodule

// File: rtl/pool_sched.sv
// Pooling scheduler: collects L columns per lane into the pooler row buffer,
// triggers the compare, waits for the pooled row, and sequences NROW rows.
// Define POOL_SCHED_RR_EN to serialise lane accepts through pool_rr_arb.
module pool_sched
  import pool_pkg::*;
#(
  parameter int W    = 8,
  parameter int L    = 6,
  parameter int NROW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NLANE-1:0]    lane_vld,
  input  logic [NLANE*W-1:0]  lane_data,
  output logic [NLANE-1:0]    lane_rdy,
  output logic [NLANE-1:0]    wr_en,
  output logic [NLANE*CW-1:0] wr_col,
  output logic [NLANE*W-1:0]  wr_data,
  output logic                pool_go,
  output logic                row_vld,
  output logic [3:0]          row_idx,
  output logic                busy,
  output logic                done
);

  state_t                      state;
  logic [NLANE-1:0][CW-1:0]    cnt;
  logic [NLANE-1:0][CW-1:0]    cnt_nxt;
  logic [NLANE-1:0]            open_lane;
  logic [NLANE-1:0]            acc;
  logic                        all_full;
  logic [1:0]                  wcnt;

  // Lanes still short of L columns, gated to the FILL state
  always_comb begin
    open_lane = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      open_lane[k] = (state == FILL) && (cnt[k] != CW'(L));
    end
  end

`ifdef POOL_SCHED_RR_EN
  pool_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (lane_vld & open_lane),
    .grant (lane_rdy)
  );
`else
  assign lane_rdy = open_lane;
`endif

  assign acc  = lane_vld & lane_rdy;
  assign busy = (state != IDLE);

  // Post-accept counters; row is complete when every lane reaches L
  always_comb begin
    cnt_nxt  = cnt;
    all_full = 1'b1;
    for (int unsigned k = 0; k < NLANE; k++) begin
      if (acc[k]) cnt_nxt[k] = cnt[k] + 1'b1;
      if (cnt_nxt[k] != CW'(L)) all_full = 1'b0;
    end
  end

  // Row-buffer write path: registered copy of each accepted sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= '0;
      wr_col  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= acc;
      for (int unsigned k = 0; k < NLANE; k++) begin
        if (acc[k]) begin
          wr_data[k*W +: W]   <= lane_data[k*W +: W];
          wr_col[k*CW +: CW]  <= cnt[k];
        end
      end
    end
  end

  // Frame sequencer with registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      row_idx <= '0;
      pool_go <= 1'b0;
      row_vld <= 1'b0;
      done    <= 1'b0;
    end else begin
      pool_go <= 1'b0;
      row_vld <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= FILL;
        end
        FILL: begin
          cnt <= cnt_nxt;
          if (all_full) begin
            state   <= POOL;
            pool_go <= 1'b1;
          end
        end
        POOL: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          // strobe is registered, so it is armed one cycle ahead of the 3rd WAIT cycle
          if (wcnt == 2'd1) row_vld <= 1'b1;
          if (wcnt == 2'd2) begin
            cnt <= '0;
            if (row_idx == 4'(NROW - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
              state   <= FILL;
            end
          end
        end
        DONE: begin
          row_idx <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 Parameter W SHALL be: W, default 8, data width of one convolution sample.
REQ-002 Parameter L SHALL be: L, default 6, columns per lane row, with L <= 7.
REQ-003 Parameter NROW SHALL be: NROW, default 12, pooled output rows per frame, with NROW <= 16.
REQ-004 Port clk SHALL be: clk  in  1  sole clock, rising edge.
REQ-005 Port rst SHALL be: rst  in  1  asynchronous, active-low reset.
REQ-006 Port start SHALL be: start  in  1  one-cycle frame start request.
REQ-007 Port lane_vld SHALL be: lane_vld  in  4  per-lane conv sample valid.
REQ-008 Port lane_data SHALL be: lane_data  in  4*W  per-lane samples, lane 0 in the LSBs.
REQ-009 Port lane_rdy SHALL be: lane_rdy  out  4  per-lane accept.
REQ-010 Port wr_en SHALL be: wr_en  out  4  pooler row-buffer write strobes.
REQ-011 Port wr_col SHALL be: wr_col  out  12  3-bit column index per lane, lane 0 in the LSBs.
REQ-012 Port wr_data SHALL be: wr_data  out  4*W  registered copy of the accepted samples.
REQ-013 Port pool_go SHALL be: pool_go  out  1  one-cycle pooler compare trigger.
REQ-014 Port row_vld SHALL be: row_vld  out  1  one-cycle strobe marking the pooler Max output as valid.
REQ-015 Port row_idx SHALL be: row_idx  out  4  index of the current pooled row.
REQ-016 Port busy SHALL be: busy  out  1  high whenever the state is not IDLE.
REQ-017 Port done SHALL be: done  out  1  one-cycle frame-complete strobe.

Function
REQ-018 The FSM SHALL have the states IDLE, FILL, POOL, WAIT and DONE.
REQ-019 IDLE SHALL go to FILL on start; a start received in any other state SHALL be ignored.
REQ-020 Accept handshake: a sample on lane k SHALL be accepted on a cycle with lane_vld[k] & lane_rdy[k].
REQ-021 On the cycle after an accept, wr_en[k] SHALL be 1, wr_data[k] SHALL hold the sample, and wr_col[k] SHALL hold the pre-increment column count of lane k.
REQ-022 Per-lane column counters SHALL run 0..L; lane_rdy[k] SHALL be 0 once counter k equals L.
REQ-023 Lane_rdy SHALL be 0 in every state other than FILL.
REQ-024 FILL SHALL go to POOL on the cycle in which all four counters equal L; the final writes SHALL land on the same edge.
REQ-025 In POOL, pool_go SHALL be 1 for exactly one cycle, and the FSM SHALL then enter WAIT.
REQ-026 WAIT SHALL last 3 cycles; row_vld SHALL pulse on the 3rd cycle, and the pulse SHALL occur 3 cycles after pool_go.
REQ-027 On row_vld, all column counters SHALL clear.
REQ-028 On row_vld with row_idx < NROW-1, row_idx SHALL increment and the FSM SHALL return to FILL.
REQ-029 On row_vld with row_idx = NROW-1, the FSM SHALL go to DONE.
REQ-030 DONE SHALL pulse done for one cycle, clear row_idx to 0, and return to IDLE.
REQ-031 A lane_vld that is held while lane_rdy is 0 SHALL cause no write and no counter change.
REQ-032 A lane SHALL NOT be written more than L times per row.

Reset
REQ-033 Reset assertion SHALL asynchronously force the FSM to IDLE, all counters and row_idx to 0, and every output to 0.
REQ-034 A reset mid-frame SHALL discard the partial row, and no row_vld or done SHALL follow it.
REQ-035 Reset release SHALL take effect on the next clk edge.

Configuration
REQ-036 With POOL_SCHED_RR_EN undefined, all lanes SHALL be ready concurrently in FILL.
REQ-037 With POOL_SCHED_RR_EN defined, at most one lane_rdy bit SHALL be high per cycle.
REQ-038 With POOL_SCHED_RR_EN defined, a round-robin pointer SHALL grant the next lane with a count below L and lane_vld high.
REQ-039 With POOL_SCHED_RR_EN defined, the pointer SHALL advance past the granted lane after each accept and SHALL reset to lane 0.

Structure
REQ-040 The FSM state encoding SHALL reside in the shared package pool_pkg.
REQ-041 The lane count constant (4) SHALL reside in pool_pkg.
REQ-042 The column-width constant (3) SHALL reside in pool_pkg.
REQ-043 The round-robin grant logic SHALL be the sub-module pool_rr_arb, instantiated only under POOL_SCHED_RR_EN.

Verification
REQ-044 Test: reset, then start, then all lanes valid with data k*16+col -> 6 cycles of wr_en=4'hF, then pool_go, then row_vld 3 cycles later with row_idx=0.
REQ-045 Test: NROW=12 full frame -> 12 row_vld pulses, done one cycle after the 12th, busy low afterwards.
REQ-046 Test: lane 2 valid withheld for 5 cycles -> pool_go delayed by exactly 5 cycles, and lane 2 wr_col still 0..5.
REQ-047 Test: start pulsed during FILL -> no effect, row_idx unchanged.
REQ-048 Test: rst low with 3 of 6 columns filled -> all outputs 0 immediately; a new start then completes the row normally.
REQ-049 Test: POOL_SCHED_RR_EN defined with all lanes valid -> grants rotate 0,1,2,3, one per cycle, and pool_go follows 24 accepts.
